eco32_core_wbu_wfifo: RTL and testbench
=======================================

ECO32_CORE_WBU_WFIFO -- requirements
Module: eco32_core_wbu_wfifo

Interface
- REQ-001 Parameter DEPTH, default 16: number of FIFO entries; power of two, 4..32.
- REQ-002 Parameter NCH, default 2: number of write-back channels per entry, 1..4.
- REQ-003 Parameter AF_LIMIT, default 1: x_af asserts when free entries <= AF_LIMIT; legal range 0..DEPTH-1.
- REQ-004 clk  in  1  single clock, rising edge.
- REQ-005 rst  in  1  reset, asynchronous, active-high.
- REQ-006 x_af  out  1  almost-full, registered, to the upstream stage.
- REQ-007 i_stb  in  1  push strobe, no ready return.
- REQ-008 i_clr, i_addr  in  1, 5  per-entry clear flag and register address.
- REQ-009 i_ena, i_mode, i_data, i_tag  in  2*NCH, NCH, 32*NCH, NCH  per-channel byte-pair enables, mode, data, tag; channel k occupies slice k.
- REQ-010 o_stb, o_clr, o_addr, o_ena, o_mode, o_data, o_tag  out  widths as inputs  head entry, first-word-fall-through.
- REQ-011 o_ack  in  1  pop; meaningful only while o_stb=1.
- REQ-012 o_cnt  out  $clog2(DEPTH)+1  current occupancy.
- REQ-013 o_err  out  1  sticky overflow flag.
- REQ-014 q_addr  in  5, q_hit  out  1  pending-write lookup port (present only with the hazard feature enabled).

Function
- REQ-015 Push: i_stb=1 and not full, or i_stb=1 with full and a same-cycle pop, writes the packed entry at the write pointer.
- REQ-016 Pop: o_stb=1 and o_ack=1 advances the read pointer; o_ack while o_stb=0 is ignored with no state change.
- REQ-017 o_stb is 1 iff o_cnt!=0; outputs show the head entry combinationally from storage.
- REQ-018 Latency: a push into an empty FIFO is visible on o_stb in the next cycle.
- REQ-019 o_cnt changes by +1 on push-only, -1 on pop-only, and 0 on simultaneous push and pop, in every occupancy state.
- REQ-020 Pointers wrap modulo DEPTH; full is o_cnt==DEPTH.
- REQ-021 Push while full without a pop drops the entry, leaves storage unchanged, and sets o_err until reset.
- REQ-022 x_af is registered from the next-state count: x_af <= (DEPTH - cnt_next) <= AF_LIMIT.
- REQ-023 Output fields are bit-exact copies of input fields; i_clr is carried as data, not interpreted.

Reset
- REQ-024 rst asserted, at any time including mid-push or mid-pop: pointers=0, o_cnt=0, o_stb=0, x_af=0 (or x_af=1 when AF_LIMIT>=DEPTH-0 is impossible), o_err=0, q_hit=0; storage contents are don't-care.
- REQ-025 Storage RAM has no reset; reset deassertion is used synchronously inside the block.

Configuration
- REQ-026 With macro ECO32_CORE_WBU_WFIFO_HAZARD_EN defined: q_addr/q_hit exist; q_hit=1 combinationally iff some valid entry has o_addr==q_addr and any ena bit set in any channel, with the entry being popped this cycle still counted.
- REQ-027 Without ECO32_CORE_WBU_WFIFO_HAZARD_EN: q_addr and q_hit are absent and no per-entry valid or compare logic is built.

Structure
- REQ-028 Shared package eco32_core_wbu_pkg holds the entry field widths (ADDR_W=5, DATA_W=32, ENA_W=2) and an entry-width function of NCH.
- REQ-029 One sub-module, eco32_core_wbu_wfifo_mem: a DEPTH x entry-width distributed RAM with one write port and one asynchronous read port.

Verification
- REQ-030 Reset, then push 1 entry {addr=5, data0=0xDEADBEEF} -> o_stb=1 the next cycle with the same fields and o_cnt=1.
- REQ-031 DEPTH=16, AF_LIMIT=1: 15 pushes with no pops -> x_af=1 after the 15th; a 16th push gives o_cnt=16; a 17th push sets o_err=1 and o_cnt stays 16.
- REQ-032 Full FIFO, simultaneous push and pop -> o_cnt stays 16, o_err=0, and the new entry is popped last in order.
- REQ-033 20 push/pop pairs, then 40 interleaved entries -> output order matches input order across pointer wrap.
- REQ-034 HAZARD_EN: queued entries with addr 3 (ena=0) and addr 7 (ena=2'b01) -> q_addr=3 gives q_hit=0, q_addr=7 gives q_hit=1; after addr 7 is popped, q_hit=0.
- REQ-035 rst asserted mid-stream with o_cnt=9 -> o_stb, o_cnt, x_af, and o_err all 0 on the following cycle.

Source files
------------

// File: rtl/eco32_core_wbu_pkg.sv
// Shared write-back unit definitions: entry field widths and packed entry width.
package eco32_core_wbu_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ENA_W  = 2;

  // Per-channel payload: byte-pair enables, mode, data, tag.
  localparam int unsigned CH_W = ENA_W + 1 + DATA_W + 1;

  // Packed entry: {clr, addr, ena[], mode[], data[], tag[]}.
  function automatic int unsigned entry_w(input int unsigned nch);
    return 1 + ADDR_W + nch * CH_W;
  endfunction

endpackage

// File: rtl/eco32_core_wbu_wfifo_mem.sv
// DEPTH x WIDTH distributed RAM: one synchronous write port, one asynchronous read port.
// No reset on the storage array.
module eco32_core_wbu_wfifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 78
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/eco32_core_wbu_wfifo.sv
// Write-back FIFO with first-word-fall-through head, registered almost-full and
// sticky overflow flag. Optional pending-write lookup port enabled by the macro
// ECO32_CORE_WBU_WFIFO_HAZARD_EN (q_addr/q_hit).
module eco32_core_wbu_wfifo
  import eco32_core_wbu_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NCH      = 2,
  parameter int unsigned AF_LIMIT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     x_af,
  input  logic                     i_stb,
  input  logic                     i_clr,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [ENA_W*NCH-1:0]     i_ena,
  input  logic [NCH-1:0]           i_mode,
  input  logic [DATA_W*NCH-1:0]    i_data,
  input  logic [NCH-1:0]           i_tag,
  output logic                     o_stb,
  output logic                     o_clr,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [ENA_W*NCH-1:0]     o_ena,
  output logic [NCH-1:0]           o_mode,
  output logic [DATA_W*NCH-1:0]    o_data,
  output logic [NCH-1:0]           o_tag,
  input  logic                     o_ack,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_err
`ifdef ECO32_CORE_WBU_WFIFO_HAZARD_EN
  ,
  input  logic [ADDR_W-1:0]        q_addr,
  output logic                     q_hit
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = entry_w(NCH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_af;
  logic          r_err;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_rdata;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = (r_cnt != '0) && o_ack;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_stb && (!w_full || w_pop);
  assign w_ovf   = i_stb && w_full && !w_pop;
  assign w_wdata = {i_clr, i_addr, i_ena, i_mode, i_data, i_tag};

  eco32_core_wbu_wfifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Next occupancy from push/pop combination.
  always_comb begin
    w_cnt_next = r_cnt;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_next = r_cnt + 1'b1;
      2'b01:   w_cnt_next = r_cnt - 1'b1;
      default: w_cnt_next = r_cnt;
    endcase
  end

  // Pointers, occupancy, almost-full and sticky overflow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_af     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt <= w_cnt_next;
      r_af  <= (CW'(DEPTH) - w_cnt_next) <= CW'(AF_LIMIT);
      if (w_ovf) r_err <= 1'b1;
    end
  end

  assign x_af  = r_af;
  assign o_err = r_err;
  assign o_cnt = r_cnt;
  assign o_stb = (r_cnt != '0);
  assign {o_clr, o_addr, o_ena, o_mode, o_data, o_tag} = w_rdata;

`ifdef ECO32_CORE_WBU_WFIFO_HAZARD_EN
  // Shadow copy of each slot's address and any-enable bit, for parallel compare.
  logic [ADDR_W-1:0] r_haddr [DEPTH];
  logic              r_hena  [DEPTH];

  // Shadow write alongside the RAM write.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_haddr[r_wr_ptr] <= i_addr;
      r_hena[r_wr_ptr]  <= |i_ena;
    end
  end

  // Slot i is valid when its distance from the read pointer is below the count;
  // the head being popped this cycle is still counted.
  always_comb begin
    logic [AW-1:0] off;
    off   = '0;
    q_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off = AW'(i) - r_rd_ptr;
      if (({1'b0, off} < r_cnt) && r_hena[i] && (r_haddr[i] == q_addr)) q_hit = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_eco32_core_wbu_wfifo.sv
// Self-checking bench for eco32_core_wbu_wfifo: directed phases with random payloads,
// checked against a queue-based reference model.
module tb_eco32_core_wbu_wfifo;
  import eco32_core_wbu_pkg::*;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned NCH      = 2;
  localparam int unsigned AF_LIMIT = 1;
  localparam int unsigned EW       = entry_w(NCH);
  localparam int unsigned ENA_LSB  = NCH + DATA_W * NCH + NCH;
  localparam int unsigned ADDR_LSB = ENA_LSB + ENA_W * NCH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  x_af;
  logic                  i_stb = 1'b0;
  logic                  i_clr = 1'b0;
  logic [ADDR_W-1:0]     i_addr = '0;
  logic [ENA_W*NCH-1:0]  i_ena = '0;
  logic [NCH-1:0]        i_mode = '0;
  logic [DATA_W*NCH-1:0] i_data = '0;
  logic [NCH-1:0]        i_tag = '0;
  logic                  o_stb;
  logic                  o_clr;
  logic [ADDR_W-1:0]     o_addr;
  logic [ENA_W*NCH-1:0]  o_ena;
  logic [NCH-1:0]        o_mode;
  logic [DATA_W*NCH-1:0] o_data;
  logic [NCH-1:0]        o_tag;
  logic                  o_ack = 1'b0;
  logic [$clog2(DEPTH):0] o_cnt;
  logic                  o_err;
`ifdef ECO32_CORE_WBU_WFIFO_HAZARD_EN
  logic [ADDR_W-1:0]     q_addr = '0;
  logic                  q_hit;
`endif

  eco32_core_wbu_wfifo #(
    .DEPTH    (DEPTH),
    .NCH      (NCH),
    .AF_LIMIT (AF_LIMIT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .x_af   (x_af),
    .i_stb  (i_stb),
    .i_clr  (i_clr),
    .i_addr (i_addr),
    .i_ena  (i_ena),
    .i_mode (i_mode),
    .i_data (i_data),
    .i_tag  (i_tag),
    .o_stb  (o_stb),
    .o_clr  (o_clr),
    .o_addr (o_addr),
    .o_ena  (o_ena),
    .o_mode (o_mode),
    .o_data (o_data),
    .o_tag  (o_tag),
    .o_ack  (o_ack),
    .o_cnt  (o_cnt),
    .o_err  (o_err)
`ifdef ECO32_CORE_WBU_WFIFO_HAZARD_EN
    ,
    .q_addr (q_addr),
    .q_hit  (q_hit)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: ordered list of queued entries plus sticky error.
  logic [EW-1:0] mq[$];
  logic          m_err = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] rnd_entry();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[EW-1:0];
  endfunction

  function automatic logic [EW-1:0] mk_entry(input logic [4:0] addr,
                                             input logic [ENA_W*NCH-1:0] ena,
                                             input logic [31:0] d0);
    logic [DATA_W*NCH-1:0] d;
    logic [NCH-1:0]        z;
    d       = '0;
    d[31:0] = d0;
    z       = '0;
    return {1'b0, addr, ena, z, d, z};
  endfunction

  function automatic logic ref_hit(input logic [4:0] a);
    foreach (mq[i]) begin
      if (mq[i][ADDR_LSB +: ADDR_W] == a && mq[i][ENA_LSB +: ENA_W * NCH] != '0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: drive, check head (and lookup) before the edge, update model, check state after.
  task automatic step(input logic p, input logic a, input logic [EW-1:0] e,
                      input logic [4:0] qa);
    logic pop;
    @(negedge clk);
    i_stb = p;
    o_ack = a;
    {i_clr, i_addr, i_ena, i_mode, i_data, i_tag} = e;
`ifdef ECO32_CORE_WBU_WFIFO_HAZARD_EN
    q_addr = qa;
`else
    if (qa == 5'h1f && p === 1'bx) $display("unreachable");
`endif
    #1;
    chk("o_stb", o_stb, mq.size() != 0);
    if (mq.size() != 0)
      chk("head", {o_clr, o_addr, o_ena, o_mode, o_data, o_tag}, mq[0]);
`ifdef ECO32_CORE_WBU_WFIFO_HAZARD_EN
    chk("q_hit", q_hit, ref_hit(qa));
`endif
    @(posedge clk);
    #1;
    pop = a && (mq.size() != 0);
    if (p && mq.size() == DEPTH && !pop) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    if (p && mq.size() < DEPTH) mq.push_back(e);
    chk("o_cnt", o_cnt, mq.size());
    chk("x_af", x_af, (DEPTH - mq.size()) <= AF_LIMIT);
    chk("o_err", o_err, m_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    i_stb = 1'b0;
    o_ack = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    m_err = 1'b0;
    chk("rst_stb", o_stb, 1'b0);
    chk("rst_cnt", o_cnt, 0);
    chk("rst_af", x_af, 1'b0);
    chk("rst_err", o_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state.
    do_reset();

    // Single push into empty FIFO is visible next cycle.
    step(1'b1, 1'b0, mk_entry(5'd5, '0, 32'hDEADBEEF), 5'd5);
    chk("first_stb", o_stb, 1'b1);
    chk("first_addr", o_addr, 5'd5);
    chk("first_data0", o_data[31:0], 32'hDEADBEEF);
    step(1'b0, 1'b1, '0, 5'd0);

    // Fill towards full: almost-full after 15, full at 16, overflow at 17.
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, rnd_entry(), 5'($urandom));
    chk("af_after_15", x_af, 1'b1);
    step(1'b1, 1'b0, rnd_entry(), 5'($urandom));
    chk("cnt_full", o_cnt, 16);
    step(1'b1, 1'b0, rnd_entry(), 5'($urandom));
    chk("ovf_err", o_err, 1'b1);
    chk("ovf_cnt", o_cnt, 16);

    // Full FIFO with simultaneous push and pop, then drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, rnd_entry(), 5'($urandom));
    step(1'b1, 1'b1, mk_entry(5'd9, 4'b0011, 32'h1234_5678), 5'd9);
    chk("fullpp_cnt", o_cnt, 16);
    chk("fullpp_err", o_err, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0, 5'($urandom));
    chk("drained", o_stb, 1'b0);

    // Ack on empty is ignored; then push/pop pairs across pointer wrap.
    step(1'b0, 1'b1, '0, 5'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, rnd_entry(), 5'($urandom));
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), rnd_entry(),
           5'($urandom));
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), rnd_entry(),
           5'($urandom));
    while (mq.size() != 0) step(1'b0, 1'b1, '0, 5'($urandom));

`ifdef ECO32_CORE_WBU_WFIFO_HAZARD_EN
    // Lookup: addr 3 without enables never hits, addr 7 with enables does until popped.
    do_reset();
    step(1'b1, 1'b0, mk_entry(5'd3, 4'b0000, 32'h0), 5'd3);
    step(1'b1, 1'b0, mk_entry(5'd7, 4'b0001, 32'h0), 5'd7);
    step(1'b0, 1'b0, '0, 5'd3);
    step(1'b0, 1'b1, '0, 5'd7);
    step(1'b0, 1'b1, '0, 5'd7);
    step(1'b0, 1'b0, '0, 5'd7);
`endif

    // Asynchronous reset in the middle of a push with nine entries queued.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, rnd_entry(), 5'($urandom));
    chk("pre_rst_cnt", o_cnt, 9);
    @(negedge clk);
    i_stb = 1'b1;
    o_ack = 1'b1;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    m_err = 1'b0;
    chk("mid_rst_stb", o_stb, 1'b0);
    chk("mid_rst_cnt", o_cnt, 0);
    chk("mid_rst_af", x_af, 1'b0);
    chk("mid_rst_err", o_err, 1'b0);
    @(negedge clk);
    rst   = 1'b0;
    i_stb = 1'b0;
    o_ack = 1'b0;
    step(1'b0, 1'b0, '0, 5'd0);
    step(1'b1, 1'b0, rnd_entry(), 5'd0);
    step(1'b0, 1'b1, '0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
